timer_dev: RTL
==============

TIMER_DEV -- requirements
Module: timer_dev

Interface
REQ-001 SHALL have clk, input, 1, sole clock, all state updates on rising edge.
REQ-002 SHALL have rst_n, input, 1, reset, asynchronous and active-low.
REQ-003 SHALL have addr, input, 2 ([3:2]), word select: 0 CTRL, 1 PRESET, 2 COUNT, 3 reserved.
REQ-004 SHALL have we, input, 1, write strobe, sampled on the rising edge.
REQ-005 SHALL have din, input, 32, write data.
REQ-006 SHALL have dout, output, 32, combinational read data for addr.
REQ-007 SHALL have irq, output, 1, registered interrupt request, intended for one HWInt bit of the coprocessor-0 interrupt inputs.

Function
REQ-008 CTRL SHALL hold en (bit0), mode (bits2:1; 00 one-shot, 01 auto-reload, 1x treated as 00) and im (bit3); bits31:4 read 0.
REQ-009 PRESET SHALL be 32-bit read/write; COUNT SHALL be read-only, and writes to it are ignored.
REQ-010 Reads SHALL return: addr0 {28'b0, im, mode, en}; addr1 PRESET; addr2 COUNT; addr3 32'h0.
REQ-011 FSM states SHALL be IDLE, LOAD, CNT, INT.
REQ-012 IDLE SHALL go to LOAD on the edge after en=1; COUNT holds.
REQ-013 LOAD SHALL load COUNT<=PRESET and go to CNT in one cycle.
REQ-014 CNT SHALL go: en=0 -> IDLE with COUNT held; COUNT>1 -> COUNT-1; COUNT<=1 -> COUNT<=0, go to INT, set irq_pend.
REQ-015 Timing SHALL be: after the enabling write edge E0, irq rises after edge E(N+1) for PRESET=N>=1; PRESET 0 and 1 both give irq after E2.
REQ-016 INT in mode 00 SHALL clear en by hardware, go to IDLE, and keep irq_pend set until any write to CTRL or PRESET.
REQ-017 INT in mode 01 SHALL go to LOAD and clear irq_pend, giving a 1-cycle irq pulse and an interrupt period of N+2 cycles.
REQ-018 irq SHALL equal irq_pend & im.
REQ-019 A PRESET write while en=1 SHALL force LOAD on the next edge, restarting the count with the new value.
REQ-020 A CTRL write with en=0 SHALL force IDLE from any state.
REQ-021 On a simultaneous software CTRL write and hardware en clear (INT, mode 00), the software value SHALL win.
REQ-022 On a simultaneous write and irq_pend set, the write-clear SHALL win and irq_pend SHALL stay 0.
REQ-023 COUNT SHALL never wrap below 0.

Reset
REQ-024 rst_n low SHALL immediately force state IDLE and zero CTRL, PRESET, COUNT, irq_pend and irq, so dout reads 0 at every address.
REQ-025 Reset asserted mid-count SHALL abort with no irq; counting resumes only after a new en write following release.

Structure
REQ-026 A shared package timer_pkg SHALL hold the register address constants, the FSM state encodings, the mode encodings and the CTRL bit positions.
REQ-027 timer_dev SHALL be a single module with no sub-module; FSM and register file are in one unit.

Verification
REQ-028 One-shot: PRESET=3, CTRL=0x9 at E0 -> COUNT 3,2,1,0 at E1..E4; irq=1 after E4; CTRL reads 0x8; irq stays high until a CTRL write.
REQ-029 Auto-reload: PRESET=2, CTRL=0xB -> irq 1-cycle pulses every 4 cycles, first after E3; en stays 1.
REQ-030 Masked: PRESET=1, CTRL=0x1 -> COUNT reaches 0, irq stays 0; then write CTRL=0x8 -> irq still 0 (pend cleared by write).
REQ-031 Restart: PRESET=10, en=1; at COUNT=5 write PRESET=2 -> LOAD next edge, COUNT=2, irq 3 cycles after load.
REQ-032 Abort and reset: mid-count CTRL=0 -> IDLE, COUNT frozen, no irq; separately, rst_n low mid-count -> all reads 0, irq 0 immediately, before any clock edge.

Source files
------------

// File: rtl/timer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : timer_pkg
// Purpose  : Register map, FSM state, mode and CTRL bit-field constants for timer_dev.
// Revision : 1.0
// ============================================================================
package timer_pkg;

    localparam logic [1:0] c_addr_ctrl   = 2'd0;
    localparam logic [1:0] c_addr_preset = 2'd1;
    localparam logic [1:0] c_addr_count  = 2'd2;
    localparam logic [1:0] c_addr_rsvd   = 2'd3;

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_load = 2'd1;
    localparam logic [1:0] c_st_cnt  = 2'd2;
    localparam logic [1:0] c_st_int  = 2'd3;

    localparam logic [1:0] c_mode_oneshot = 2'b00;
    localparam logic [1:0] c_mode_auto    = 2'b01;

    localparam int c_ctrl_en      = 0;
    localparam int c_ctrl_mode_lo = 1;
    localparam int c_ctrl_mode_hi = 2;
    localparam int c_ctrl_im      = 3;

endpackage
`default_nettype wire

// File: rtl/timer_dev.sv
`default_nettype none
// ============================================================================
// Module   : timer_dev
// Purpose  : Memory-mapped down-counting timer with one-shot / auto-reload
//            modes and a maskable registered interrupt.
// Revision : 1.0
// ============================================================================
module timer_dev
    import timer_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:2]  addr,
    input  logic        we,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        irq
);

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic        r_en;
    logic [1:0]  r_mode;
    logic        r_im;
    logic [31:0] r_preset;
    logic [31:0] r_count;
    logic        r_pend;
    logic        r_irq;

    logic        w_wr_ctrl;
    logic        w_wr_preset;
    logic        w_en_eff;
    logic        w_auto;
    logic        w_load;
    logic        w_dec;
    logic        w_expire;
    logic        w_hw_clr_en;
    logic        w_hw_clr_pend;
    logic        w_pend_nxt;
    logic        w_im_nxt;

    assign w_wr_ctrl   = we && (addr == c_addr_ctrl);
    assign w_wr_preset = we && (addr == c_addr_preset);
    // A CTRL write in the same cycle takes effect immediately for sequencing.
    assign w_en_eff    = w_wr_ctrl ? din[c_ctrl_en] : r_en;
    assign w_auto      = (r_mode == c_mode_auto);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_wr_ctrl && !din[c_ctrl_en]) begin
            w_state_nxt = c_st_idle;
        end else if (w_wr_preset && w_en_eff) begin
            w_state_nxt = c_st_load;
        end else begin
            case (r_state)
                c_st_idle: if (w_en_eff) w_state_nxt = c_st_load;
                c_st_load: w_state_nxt = c_st_cnt;
                c_st_cnt: begin
                    if (!w_en_eff)              w_state_nxt = c_st_idle;
                    else if (r_count <= 32'd1)  w_state_nxt = c_st_int;
                end
                c_st_int:  w_state_nxt = w_auto ? c_st_load : c_st_idle;
                default:   w_state_nxt = c_st_idle;
            endcase
        end
    end

    always_comb begin
        w_load        = (r_state == c_st_load) && (w_state_nxt == c_st_cnt);
        w_dec         = (r_state == c_st_cnt)  && (w_state_nxt == c_st_cnt);
        w_expire      = (r_state == c_st_cnt)  && (w_state_nxt == c_st_int);
        w_hw_clr_en   = (r_state == c_st_int)  && !w_auto;
        w_hw_clr_pend = (r_state == c_st_int)  && w_auto;
    end

    // Software writes dominate every hardware set/clear of the same cycle.
    always_comb begin
        w_pend_nxt = r_pend;
        if (w_wr_ctrl || w_wr_preset) w_pend_nxt = 1'b0;
        else if (w_expire)            w_pend_nxt = 1'b1;
        else if (w_hw_clr_pend)       w_pend_nxt = 1'b0;
        w_im_nxt = w_wr_ctrl ? din[c_ctrl_im] : r_im;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_en     <= 1'b0;
            r_mode   <= c_mode_oneshot;
            r_im     <= 1'b0;
            r_preset <= 32'd0;
            r_count  <= 32'd0;
            r_pend   <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            if (w_wr_ctrl) begin
                r_en   <= din[c_ctrl_en];
                r_mode <= din[c_ctrl_mode_hi:c_ctrl_mode_lo];
            end else if (w_hw_clr_en) begin
                r_en   <= 1'b0;
            end
            r_im <= w_im_nxt;
            if (w_wr_preset) r_preset <= din;
            if (w_load)        r_count <= r_preset;
            else if (w_expire) r_count <= 32'd0;
            else if (w_dec)    r_count <= r_count - 32'd1;
            r_pend <= w_pend_nxt;
            r_irq  <= w_pend_nxt & w_im_nxt;
        end
    end

    always_comb begin
        case (addr)
            c_addr_ctrl:   dout = {28'd0, r_im, r_mode, r_en};
            c_addr_preset: dout = r_preset;
            c_addr_count:  dout = r_count;
            default:       dout = 32'd0;
        endcase
    end

    assign irq = r_irq;

endmodule
`default_nettype wire
